// File: rtl/adc_sample_proc_if.sv
// Handshake and data bundle for adc_sample_proc: SPI ADC results in, averaged samples out.
// The slave modport is the processing block's view; master is the driver/consumer side.
interface adc_sample_proc_if;
  logic        spi_done;
  logic [19:0] spi_data_a;
  logic [19:0] spi_data_b;
  logic        cal_req;
  logic        out_ready;
  logic        out_valid;
  logic [19:0] out_a;
  logic [19:0] out_b;
  logic        cal_busy;
  logic        overrun;
  logic        clr_overrun;

  modport master (
    output spi_done, spi_data_a, spi_data_b, cal_req, out_ready, clr_overrun,
    input  out_valid, out_a, out_b, cal_busy, overrun
  );

  modport slave (
    input  spi_done, spi_data_a, spi_data_b, cal_req, out_ready, clr_overrun,
    output out_valid, out_a, out_b, cal_busy, overrun
  );
endinterface

// File: rtl/adc_sample_proc.sv
// Dual-channel ADC sample processor: offset calibration (CAL), then offset-corrected,
// saturated, block-averaged results (RUN) behind a valid/ready output with overrun flag.
module adc_sample_proc #(
  parameter int unsigned CAL_LOG2 = 4,
  parameter int unsigned AVG_LOG2 = 2
) (
  input logic               clk,
  input logic               sys_rst_n,
  adc_sample_proc_if.slave  bus
);

  localparam int unsigned CalW = 20 + CAL_LOG2;
  localparam int unsigned AvgW = 20 + AVG_LOG2;
  localparam logic [8:0]  CalLast = 9'((32'd1 << CAL_LOG2) - 32'd1);
  localparam logic [8:0]  AvgLast = 9'((32'd1 << AVG_LOG2) - 32'd1);

  typedef enum logic {StCal, StRun} state_e;

  state_e                   state_q, state_d;
  logic [8:0]               cnt_q, cnt_d;
  logic                     s1_valid_q, s1_valid_d;
  logic signed [19:0]       s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic signed [CalW-1:0]   cal_acc_a_q, cal_acc_a_d, cal_acc_b_q, cal_acc_b_d;
  logic signed [AvgW-1:0]   avg_acc_a_q, avg_acc_a_d, avg_acc_b_q, avg_acc_b_d;
  logic signed [19:0]       offset_a_q, offset_a_d, offset_b_q, offset_b_d;
  logic                     out_valid_q, out_valid_d;
  logic [19:0]              out_a_q, out_a_d, out_b_q, out_b_d;
  logic                     overrun_q, overrun_d;

  logic signed [CalW-1:0]   cal_sum_a, cal_sum_b;
  logic signed [19:0]       corr_a, corr_b;
  logic signed [AvgW-1:0]   avg_sum_a, avg_sum_b;
  logic                     new_res;
  logic [19:0]              res_a, res_b;

  // Clamp a 21-bit difference into the 20-bit two's complement range.
  function automatic logic signed [19:0] sat20(input logic signed [20:0] v);
    logic signed [19:0] r;
    if (v[20] != v[19]) begin
      r = v[20] ? 20'sh80000 : 20'sh7FFFF;
    end else begin
      r = v[19:0];
    end
    return r;
  endfunction

  always_comb begin
    cal_sum_a = cal_acc_a_q + CalW'(s1_a_q);
    cal_sum_b = cal_acc_b_q + CalW'(s1_b_q);
    corr_a    = sat20(21'(s1_a_q) - 21'(offset_a_q));
    corr_b    = sat20(21'(s1_b_q) - 21'(offset_b_q));
    avg_sum_a = avg_acc_a_q + AvgW'(corr_a);
    avg_sum_b = avg_acc_b_q + AvgW'(corr_b);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    s1_valid_d  = bus.spi_done;
    s1_a_d      = bus.spi_done ? signed'(bus.spi_data_a) : s1_a_q;
    s1_b_d      = bus.spi_done ? signed'(bus.spi_data_b) : s1_b_q;
    cal_acc_a_d = cal_acc_a_q;
    cal_acc_b_d = cal_acc_b_q;
    avg_acc_a_d = avg_acc_a_q;
    avg_acc_b_d = avg_acc_b_q;
    offset_a_d  = offset_a_q;
    offset_b_d  = offset_b_q;
    out_valid_d = out_valid_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    overrun_d   = overrun_q;
    new_res     = 1'b0;
    res_a       = 20'(avg_sum_a >>> AVG_LOG2);
    res_b       = 20'(avg_sum_b >>> AVG_LOG2);

    // Recalibration wins over any sample: the coincident and in-flight samples are dropped.
    if (bus.cal_req) begin
      state_d     = StCal;
      cnt_d       = '0;
      s1_valid_d  = 1'b0;
      cal_acc_a_d = '0;
      cal_acc_b_d = '0;
      avg_acc_a_d = '0;
      avg_acc_b_d = '0;
    end else if (s1_valid_q) begin
      unique case (state_q)
        StCal: begin
          if (cnt_q == CalLast) begin
            offset_a_d  = 20'(cal_sum_a >>> CAL_LOG2);
            offset_b_d  = 20'(cal_sum_b >>> CAL_LOG2);
            cal_acc_a_d = '0;
            cal_acc_b_d = '0;
            cnt_d       = '0;
            state_d     = StRun;
          end else begin
            cal_acc_a_d = cal_sum_a;
            cal_acc_b_d = cal_sum_b;
            cnt_d       = cnt_q + 9'd1;
          end
        end
        StRun: begin
          if (cnt_q == AvgLast) begin
            new_res     = 1'b1;
            avg_acc_a_d = '0;
            avg_acc_b_d = '0;
            cnt_d       = '0;
          end else begin
            avg_acc_a_d = avg_sum_a;
            avg_acc_b_d = avg_sum_b;
            cnt_d       = cnt_q + 9'd1;
          end
        end
        default: state_d = StCal;
      endcase
    end

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    if (bus.clr_overrun) begin
      overrun_d = 1'b0;
    end
    if (new_res) begin
      if (!out_valid_q || bus.out_ready) begin
        out_valid_d = 1'b1;
        out_a_d     = res_a;
        out_b_d     = res_b;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= StCal;
      cnt_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      cal_acc_a_q <= '0;
      cal_acc_b_q <= '0;
      avg_acc_a_q <= '0;
      avg_acc_b_q <= '0;
      offset_a_q  <= '0;
      offset_b_q  <= '0;
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      cal_acc_a_q <= cal_acc_a_d;
      cal_acc_b_q <= cal_acc_b_d;
      avg_acc_a_q <= avg_acc_a_d;
      avg_acc_b_q <= avg_acc_b_d;
      offset_a_q  <= offset_a_d;
      offset_b_q  <= offset_b_d;
      out_valid_q <= out_valid_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_a     = out_a_q;
  assign bus.out_b     = out_b_q;
  assign bus.cal_busy  = (state_q == StCal);
  assign bus.overrun   = overrun_q;

endmodule

// File: doc/adc_sample_proc.md
ADC_SAMPLE_PROC -- requirements
Module: adc_sample_proc

Interface
REQ-001 SHALL have parameter CAL_LOG2, default 4, log2 of the number of samples averaged to form the offset (range 1-8).
REQ-002 SHALL have parameter AVG_LOG2, default 2, log2 of the number of corrected samples averaged per output (range 0-8).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port sys_rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port spi_done  input  1  one-cycle pulse from the dual-channel SPI ADC driver; the conversion result is valid on spi_data_a/b in that cycle.
REQ-006 SHALL have port spi_data_a  input  20  channel A sample, two's complement.
REQ-007 SHALL have port spi_data_b  input  20  channel B sample, two's complement.
REQ-008 SHALL have port cal_req  input  1  pulse that requests recalibration.
REQ-009 SHALL have port out_ready  input  1  consumer ready.
REQ-010 SHALL have port out_valid  output  1  averaged result available.
REQ-011 SHALL have ports out_a and out_b  output  20  each  averaged, offset-corrected samples, two's complement.
REQ-012 SHALL have port cal_busy  output  1  high while in CAL.
REQ-013 SHALL have port overrun  output  1  sticky flag: a result was dropped.
REQ-014 SHALL have port clr_overrun  input  1  synchronous clear of overrun.

Function
REQ-015 SHALL implement two states: CAL and RUN.
REQ-016 SHALL enter CAL from reset with the sample counter and accumulators at 0.
REQ-017 SHALL register spi_data_a/b on the edge ending a cycle with spi_done=1 (stage 1, edge T+1) and SHALL process that sample at edge T+2.
REQ-018 In CAL, SHALL add each sample into signed accumulators of width 20+CAL_LOG2; on the 2^CAL_LOG2-th sample, SHALL set offset_a/b = acc >>> CAL_LOG2 (arithmetic shift, truncation toward minus infinity), clear the accumulators and counter, and go to RUN.
REQ-019 In RUN, SHALL compute corr = sample - offset in 21 bits and SHALL saturate it to the 20-bit signed range [0x80000, 0x7FFFF].
REQ-020 In RUN, SHALL accumulate corr in width 20+AVG_LOG2; on the 2^AVG_LOG2-th sample, SHALL form the result as acc >>> AVG_LOG2, clear the accumulator, and offer the result at edge T+2 of that last sample.
REQ-021 Output handshake: SHALL transfer a result on a cycle with out_valid=1 and out_ready=1; SHALL hold out_a/b stable while out_valid=1 and out_ready=0.
REQ-022 SHALL load a new result if out_valid=0, or if out_ready=1 in the same cycle, and SHALL keep out_valid=1 in the latter case.
REQ-023 SHALL discard a new result that arrives while out_valid=1 and out_ready=0, keep the old result, and set overrun=1.
REQ-024 On cal_req, SHALL go to CAL (also from CAL, restarting it), clear counters and accumulators, and drop any in-flight stage-1 sample; offsets SHALL keep their old values until the new calibration completes.
REQ-025 If cal_req and spi_done occur in the same cycle, cal_req SHALL win and that sample SHALL be discarded.
REQ-026 A pending out_valid result SHALL survive cal_req and SHALL remain until it is consumed.
REQ-027 No result SHALL be produced in CAL, and cal_busy SHALL be high exactly in CAL.
REQ-028 If clr_overrun and a new overrun event occur in the same cycle, the set SHALL win.
REQ-029 spi_done pulses SHALL be at least 3 cycles apart; behaviour for closer pulses is not required.

Reset
REQ-030 Asserting sys_rst_n=0 at any time SHALL immediately force the following: state=CAL, out_valid=0, out_a=out_b=0, cal_busy=1, overrun=0, offsets=0, accumulators/counters/stage-1=0.
REQ-031 Reset asserted mid-calibration or mid-average SHALL discard all partial data.

Verification
REQ-032 Calibration plus average: CAL_LOG2=4, AVG_LOG2=2.
  - Stimulus: 16 samples of a=0x00010, b=0xFFFF0, then 4 samples of a=0x00014, b=0xFFFF0.
  - Required: cal_busy falls 2 cycles after the 16th spi_done; out_valid rises 2 cycles after the 20th spi_done with out_a=0x00004, out_b=0x00000.
REQ-033 Saturation.
  - Stimulus: calibrate with a=0xFFFF0 (offset -16), then 4 samples a=0x7FFFF.
  - Required: out_a=0x7FFFF.
  - Stimulus: calibrate with a=0x00010, then 4 samples a=0x80000.
  - Required: out_a=0x80000.
REQ-034 Overrun.
  - Stimulus: hold out_ready=0 across two complete averages.
  - Required: the first result is held unchanged and overrun=1; clr_overrun then clears it.
  - Stimulus: out_ready=1 in the same cycle a new result arrives.
  - Required: the new result is loaded and overrun stays 0.
REQ-035 Recalibration.
  - Stimulus: cal_req after 2 of 4 RUN samples, coincident with spi_done.
  - Required: that sample is discarded, cal_busy=1, the pending result is retained, and the old offset stays in use until 16 new samples complete calibration.
REQ-036 Reset.
  - Stimulus: sys_rst_n pulsed low mid-average while out_valid=1.
  - Required: all outputs immediately take their reset values, and the next result needs a full 16+4 samples.
